// File: rtl/ptw_multilevel_pkg.sv
// Shared types for the multi-level page-table walker: walk states, the PTE layout
// and the Sv32/Sv39 parameter sets.
package ptw_multilevel_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_WB_REQ,
        S_WB_WAIT,
        S_ERROR,
        S_DRAIN
    } ptw_state_e;

    // Sv39 layout; a 32-bit Sv32 PTE is zero-extended into it, so rsvd reads as zero.
    typedef struct packed {
        logic [9:0]  rsvd;
        logic [43:0] ppn;
        logic [1:0]  rsw;
        logic        d;
        logic        a;
        logic        g;
        logic        u;
        logic        x;
        logic        w;
        logic        r;
        logic        v;
    } pte_t;

    typedef struct packed {
        logic valid;
        pte_t pte;
    } tlb_update_t;

    localparam int SV32_LEVELS = 2;
    localparam int SV32_VPN_W  = 10;
    localparam int SV32_PTE_W  = 32;
    localparam int SV32_PPN_W  = 22;
    localparam int SV32_PA_W   = 34;
    localparam int SV32_VA_W   = 32;

    localparam int SV39_LEVELS = 3;
    localparam int SV39_VPN_W  = 9;
    localparam int SV39_PTE_W  = 64;
    localparam int SV39_PPN_W  = 44;
    localparam int SV39_PA_W   = 56;
    localparam int SV39_VA_W   = 39;

    function automatic pte_t to_pte(input logic [63:0] raw);
        return pte_t'(raw);
    endfunction

endpackage

// File: rtl/ptw_pte_check.sv
// Combinational classification of a fetched PTE: validity, pointer vs leaf,
// superpage alignment, access permission and the A/D-updated value.
module ptw_pte_check
    import ptw_multilevel_pkg::*;
#(
    parameter int VPN_W = 10,
    parameter int PTE_W = 32,
    parameter int PPN_W = 22,
    parameter int LVL_W = 1
) (
    input  logic [PTE_W-1:0] i_pte,
    input  logic [LVL_W-1:0] i_lvl,
    input  logic             i_instr,
    input  logic             i_store,
    input  logic             i_mxr,
    output logic             o_fault,
    output logic             o_is_ptr,
    output logic             o_changed,
    output logic [PTE_W-1:0] o_pte_new
);

    pte_t             w_pte;
    logic [PPN_W-1:0] w_ppn;
    logic [PPN_W-1:0] w_mask;
    logic             w_invalid;
    logic             w_misaligned;
    logic             w_perm_ok;
    logic             w_unused;

    assign w_pte  = to_pte(64'(i_pte));
    assign w_ppn  = PPN_W'(w_pte.ppn);
    // PPN bits that a superpage at this level must leave zero.
    assign w_mask = (PPN_W'(1) << (int'(i_lvl) * VPN_W)) - PPN_W'(1);

    assign w_invalid    = !w_pte.v || (!w_pte.r && w_pte.w) || (|w_pte.rsvd);
    assign o_is_ptr     = !w_pte.r && !w_pte.x;
    assign w_misaligned = |(w_ppn & w_mask);
    assign w_perm_ok    = (i_instr ? w_pte.x : (w_pte.r || (w_pte.x && i_mxr)))
                          && (!i_store || w_pte.w);

    assign o_fault   = w_invalid || (o_is_ptr ? (i_lvl == '0) : (w_misaligned || !w_perm_ok));
    assign o_pte_new = i_pte | PTE_W'({i_store, 7'h40});
    assign o_changed = (o_pte_new != i_pte);

    assign w_unused = ^{w_pte.rsw, w_pte.d, w_pte.a, w_pte.g, w_pte.u};

endmodule

// File: rtl/ptw_multilevel.sv
// Hardware page-table walker serving ITLB/DTLB misses with A/D write-back,
// flush handling that drains an outstanding memory response.
module ptw_multilevel
    import ptw_multilevel_pkg::*;
#(
    parameter int LEVELS = 2,
    parameter int VPN_W  = 10,
    parameter int PTE_W  = 32,
    parameter int PPN_W  = 22,
    parameter int PA_W   = 34,
    parameter int VA_W   = 32,
    parameter int ASID_W = 1,
    localparam int LVL_W = (LEVELS > 1) ? $clog2(LEVELS) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    flush_i,
    input  logic                    enable_translation_i,
    input  logic                    en_ld_st_translation_i,
    input  logic                    itlb_miss_i,
    input  logic [VA_W-1:0]         itlb_vaddr_i,
    input  logic                    dtlb_miss_i,
    input  logic [VA_W-1:0]         dtlb_vaddr_i,
    input  logic                    lsu_is_store_i,
    input  logic [PPN_W-1:0]        satp_ppn_i,
    input  logic [ASID_W-1:0]       asid_i,
    input  logic                    mxr_i,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [PA_W-1:0]         mem_addr_o,
    output logic [PTE_W-1:0]        mem_wdata_o,
    input  logic                    mem_gnt_i,
    input  logic                    mem_rvalid_i,
    input  logic [PTE_W-1:0]        mem_rdata_i,
    output logic                    tlb_upd_valid_o,
    output logic                    tlb_upd_instr_o,
    output logic [LVL_W-1:0]        tlb_upd_lvl_o,
    output logic [LEVELS*VPN_W-1:0] tlb_upd_vpn_o,
    output logic [ASID_W-1:0]       tlb_upd_asid_o,
    output logic [PTE_W-1:0]        tlb_upd_pte_o,
    output logic                    busy_o,
    output logic                    error_o,
    output logic [VA_W-1:0]         fault_addr_o,
    output logic                    itlb_miss_cnt_o,
    output logic                    dtlb_miss_cnt_o
);

    localparam int OFF_W = $clog2(PTE_W / 8);

    ptw_state_e        r_state, w_next;
    logic [VA_W-1:0]   r_vaddr;
    logic [ASID_W-1:0] r_asid;
    logic              r_store;
    logic              r_instr;
    logic [LVL_W-1:0]  r_lvl;
    logic              r_g;
    logic [PA_W-1:0]   r_ptr;
    logic [PTE_W-1:0]  r_pte;
    tlb_update_t       r_upd;

    logic              w_accept, w_take_d, w_descend, w_leaf, w_wb_done;
    logic              w_fault, w_is_ptr, w_changed;
    logic [PTE_W-1:0]  w_pte_new;
    logic [VA_W-1:0]   w_req_va;
    logic [LVL_W-1:0]  w_lvl_dn;
    logic [PTE_W-1:0]  w_gbit;

    function automatic logic [PA_W-1:0] make_ptr(input logic [PPN_W-1:0] ppn,
                                                 input logic [VA_W-1:0]  va,
                                                 input logic [LVL_W-1:0] lvl);
        logic [VPN_W-1:0] vpn;
        vpn = VPN_W'(va >> (12 + int'(lvl) * VPN_W));
        return PA_W'({ppn, vpn, {OFF_W{1'b0}}});
    endfunction

    ptw_pte_check #(
        .VPN_W(VPN_W),
        .PTE_W(PTE_W),
        .PPN_W(PPN_W),
        .LVL_W(LVL_W)
    ) u_check (
        .i_pte    (mem_rdata_i),
        .i_lvl    (r_lvl),
        .i_instr  (r_instr),
        .i_store  (r_store),
        .i_mxr    (mxr_i),
        .o_fault  (w_fault),
        .o_is_ptr (w_is_ptr),
        .o_changed(w_changed),
        .o_pte_new(w_pte_new)
    );

    assign w_req_va = w_take_d ? dtlb_vaddr_i : itlb_vaddr_i;
    assign w_lvl_dn = r_lvl - LVL_W'(1);
    assign w_gbit   = PTE_W'({r_g, 5'b0});

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        w_next    = r_state;
        mem_req_o = 1'b0;
        mem_we_o  = 1'b0;
        w_accept  = 1'b0;
        w_take_d  = 1'b0;
        w_descend = 1'b0;
        w_leaf    = 1'b0;
        w_wb_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!flush_i) begin
                    if (dtlb_miss_i && en_ld_st_translation_i) begin
                        w_accept = 1'b1;
                        w_take_d = 1'b1;
                    end else if (itlb_miss_i && enable_translation_i) begin
                        w_accept = 1'b1;
                    end
                    if (w_accept) w_next = S_RD_REQ;
                end
            end
            S_RD_REQ, S_WB_REQ: begin
                mem_req_o = 1'b1;
                mem_we_o  = (r_state == S_WB_REQ);
                if (flush_i)        w_next = mem_gnt_i ? S_DRAIN : S_IDLE;
                else if (mem_gnt_i) w_next = (r_state == S_RD_REQ) ? S_RD_WAIT : S_WB_WAIT;
            end
            S_RD_WAIT: begin
                if (flush_i) begin
                    w_next = mem_rvalid_i ? S_IDLE : S_DRAIN;
                end else if (mem_rvalid_i) begin
                    if (w_fault) begin
                        w_next = S_ERROR;
                    end else if (w_is_ptr) begin
                        w_descend = 1'b1;
                        w_next    = S_RD_REQ;
                    end else begin
                        w_leaf = 1'b1;
                        w_next = w_changed ? S_WB_REQ : S_IDLE;
                    end
                end
            end
            S_WB_WAIT: begin
                if (flush_i) begin
                    w_next = mem_rvalid_i ? S_IDLE : S_DRAIN;
                end else if (mem_rvalid_i) begin
                    w_wb_done = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            S_DRAIN: if (mem_rvalid_i || flush_i) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_vaddr <= '0;
            r_asid  <= '0;
            r_store <= 1'b0;
            r_instr <= 1'b0;
            r_lvl   <= LVL_W'(LEVELS - 1);
            r_g     <= 1'b0;
            r_ptr   <= '0;
            r_pte   <= '0;
            r_upd   <= '0;
        end else begin
            r_upd.valid <= 1'b0;
            if (w_accept) begin
                r_vaddr <= w_req_va;
                r_asid  <= asid_i;
                r_store <= w_take_d && lsu_is_store_i;
                r_instr <= !w_take_d;
                r_lvl   <= LVL_W'(LEVELS - 1);
                r_g     <= 1'b0;
                r_ptr   <= make_ptr(satp_ppn_i, w_req_va, LVL_W'(LEVELS - 1));
            end
            if (w_descend) begin
                r_lvl <= w_lvl_dn;
                r_g   <= r_g | mem_rdata_i[5];
                r_ptr <= make_ptr(mem_rdata_i[10 +: PPN_W], r_vaddr, w_lvl_dn);
            end
            if (w_leaf) begin
                r_pte <= w_pte_new;
                if (!w_changed) begin
                    r_upd.valid <= 1'b1;
                    r_upd.pte   <= to_pte(64'(w_pte_new | w_gbit));
                end
            end
            if (w_wb_done) begin
                r_upd.valid <= 1'b1;
                r_upd.pte   <= to_pte(64'(r_pte | w_gbit));
            end
        end
    end

    assign mem_addr_o      = r_ptr;
    assign mem_wdata_o     = r_pte;
    assign tlb_upd_valid_o = r_upd.valid;
    assign tlb_upd_instr_o = r_instr;
    assign tlb_upd_lvl_o   = r_lvl;
    assign tlb_upd_vpn_o   = r_vaddr[12 +: LEVELS*VPN_W];
    assign tlb_upd_asid_o  = r_asid;
    assign tlb_upd_pte_o   = PTE_W'(r_upd.pte);
    assign busy_o          = (r_state != S_IDLE);
    assign error_o         = (r_state == S_ERROR) && !flush_i;
    assign fault_addr_o    = error_o ? r_vaddr : '0;
    assign itlb_miss_cnt_o = w_accept && !w_take_d;
    assign dtlb_miss_cnt_o = w_take_d;

endmodule

// File: tb/tb_ptw_multilevel.sv
// Directed bench for ptw_multilevel: an Sv32 instance and an Sv39 instance, memory
// handshakes driven step by step with hand-computed addresses and PTEs.
module tb_ptw_multilevel;
    import ptw_multilevel_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Sv32 instance
    logic        flush, en_i, en_d, itlb_miss, dtlb_miss, is_store, mxr;
    logic [31:0] itlb_va, dtlb_va;
    logic [21:0] satp;
    logic [0:0]  asid;
    logic        mem_req, mem_we, gnt, rvalid;
    logic [33:0] mem_addr;
    logic [31:0] mem_wdata, rdata;
    logic        upd_valid, upd_instr, busy, err, icnt, dcnt;
    logic [0:0]  upd_lvl, upd_asid;
    logic [19:0] upd_vpn;
    logic [31:0] upd_pte, fault_addr;

    ptw_multilevel u_sv32 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .enable_translation_i(en_i), .en_ld_st_translation_i(en_d),
        .itlb_miss_i(itlb_miss), .itlb_vaddr_i(itlb_va),
        .dtlb_miss_i(dtlb_miss), .dtlb_vaddr_i(dtlb_va), .lsu_is_store_i(is_store),
        .satp_ppn_i(satp), .asid_i(asid), .mxr_i(mxr),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_gnt_i(gnt), .mem_rvalid_i(rvalid), .mem_rdata_i(rdata),
        .tlb_upd_valid_o(upd_valid), .tlb_upd_instr_o(upd_instr), .tlb_upd_lvl_o(upd_lvl),
        .tlb_upd_vpn_o(upd_vpn), .tlb_upd_asid_o(upd_asid), .tlb_upd_pte_o(upd_pte),
        .busy_o(busy), .error_o(err), .fault_addr_o(fault_addr),
        .itlb_miss_cnt_o(icnt), .dtlb_miss_cnt_o(dcnt)
    );

    // Sv39 instance
    logic        itlb_miss39, gnt39, rvalid39, zero39;
    logic [38:0] itlb_va39, dtlb_va39;
    logic [43:0] satp39;
    logic        mem_req39, mem_we39, upd_valid39, upd_instr39, busy39, err39, icnt39, dcnt39;
    logic [55:0] mem_addr39;
    logic [63:0] mem_wdata39, rdata39, upd_pte39;
    logic [1:0]  upd_lvl39;
    logic [26:0] upd_vpn39;
    logic [0:0]  upd_asid39;
    logic [38:0] fault_addr39;

    ptw_multilevel #(
        .LEVELS(SV39_LEVELS), .VPN_W(SV39_VPN_W), .PTE_W(SV39_PTE_W),
        .PPN_W(SV39_PPN_W), .PA_W(SV39_PA_W), .VA_W(SV39_VA_W), .ASID_W(1)
    ) u_sv39 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(zero39),
        .enable_translation_i(1'b1), .en_ld_st_translation_i(zero39),
        .itlb_miss_i(itlb_miss39), .itlb_vaddr_i(itlb_va39),
        .dtlb_miss_i(zero39), .dtlb_vaddr_i(dtlb_va39), .lsu_is_store_i(zero39),
        .satp_ppn_i(satp39), .asid_i(asid), .mxr_i(zero39),
        .mem_req_o(mem_req39), .mem_we_o(mem_we39), .mem_addr_o(mem_addr39), .mem_wdata_o(mem_wdata39),
        .mem_gnt_i(gnt39), .mem_rvalid_i(rvalid39), .mem_rdata_i(rdata39),
        .tlb_upd_valid_o(upd_valid39), .tlb_upd_instr_o(upd_instr39), .tlb_upd_lvl_o(upd_lvl39),
        .tlb_upd_vpn_o(upd_vpn39), .tlb_upd_asid_o(upd_asid39), .tlb_upd_pte_o(upd_pte39),
        .busy_o(busy39), .error_o(err39), .fault_addr_o(fault_addr39),
        .itlb_miss_cnt_o(icnt39), .dtlb_miss_cnt_o(dcnt39)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!mem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_req"}, 64'(mem_req), 64'h1);
    endtask

    task automatic rd32(input string tag, input logic [33:0] addr, input logic [31:0] data);
        wait_req(tag);
        check({tag, "_addr"}, 64'(mem_addr), 64'(addr));
        check({tag, "_we"}, 64'(mem_we), 64'h0);
        gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0; rvalid = 1'b1; rdata = data;
        @(negedge clk);
        rvalid = 1'b0;
    endtask

    task automatic wr32(input string tag, input logic [33:0] addr, input logic [31:0] data);
        wait_req(tag);
        check({tag, "_addr"}, 64'(mem_addr), 64'(addr));
        check({tag, "_we"}, 64'(mem_we), 64'h1);
        check({tag, "_wdata"}, 64'(mem_wdata), 64'(data));
        gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0; rvalid = 1'b1; rdata = '0;
        @(negedge clk);
        rvalid = 1'b0;
    endtask

    task automatic start32(input string tag, input logic is_d, input logic [31:0] va,
                           input logic st);
        if (is_d) begin dtlb_miss = 1'b1; dtlb_va = va; is_store = st; end
        else      begin itlb_miss = 1'b1; itlb_va = va; end
        #1;
        check({tag, "_icnt"}, 64'(icnt), 64'(!is_d));
        check({tag, "_dcnt"}, 64'(dcnt), 64'(is_d));
        @(negedge clk);
        itlb_miss = 1'b0; dtlb_miss = 1'b0;
    endtask

    task automatic rd39(input string tag, input logic [55:0] addr, input logic [63:0] data);
        int n = 0;
        while (!mem_req39 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_req"}, 64'(mem_req39), 64'h1);
        check({tag, "_addr"}, 64'(mem_addr39), 64'(addr));
        gnt39 = 1'b1;
        @(negedge clk);
        gnt39 = 1'b0; rvalid39 = 1'b1; rdata39 = data;
        @(negedge clk);
        rvalid39 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; en_i = 1'b1; en_d = 1'b1;
        itlb_miss = 1'b0; dtlb_miss = 1'b0; is_store = 1'b0; mxr = 1'b0;
        itlb_va = '0; dtlb_va = '0; satp = 22'h00100; asid = 1'b1;
        gnt = 1'b0; rvalid = 1'b0; rdata = '0;
        itlb_miss39 = 1'b0; gnt39 = 1'b0; rvalid39 = 1'b0; zero39 = 1'b0;
        itlb_va39 = '0; dtlb_va39 = '0; satp39 = 44'h80000; rdata39 = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_req", 64'(mem_req), 64'h0);
        check("rst_err", 64'(err), 64'h0);
        check("rst_upd", 64'(upd_valid), 64'h0);
        check("rst_lvl", 64'(upd_lvl), 64'h1);
        check("rst_lvl39", 64'(upd_lvl39), 64'h2);
        rst_n = 1'b1;
        @(negedge clk);

        // ITLB miss: L1 pointer (g set) then L0 leaf, no write-back
        start32("t1", 1'b0, 32'h0040_1000, 1'b0);
        rd32("t1_l1", 34'h0_0010_0004, 32'h0008_0021);
        rd32("t1_l0", 34'h0_0020_0004, 32'h0000_00CB);
        check("t1_upd", 64'(upd_valid), 64'h1);
        check("t1_instr", 64'(upd_instr), 64'h1);
        check("t1_lvl", 64'(upd_lvl), 64'h0);
        check("t1_vpn", 64'(upd_vpn), 64'h00401);
        check("t1_asid", 64'(upd_asid), 64'h1);
        check("t1_pte", 64'(upd_pte), 64'hEB);
        check("t1_busy", 64'(busy), 64'h0);
        check("t1_noreq", 64'(mem_req), 64'h0);
        @(negedge clk);
        check("t1_pulse", 64'(upd_valid), 64'h0);

        // Store miss: leaf with a=1,d=0 is written back with d set
        start32("t2", 1'b1, 32'h0080_3000, 1'b1);
        rd32("t2_l1", 34'h0_0010_0008, 32'h000C_0001);
        rd32("t2_l0", 34'h0_0030_000C, 32'h002A_F047);
        check("t2_noupd", 64'(upd_valid), 64'h0);
        wr32("t2_wb", 34'h0_0030_000C, 32'h002A_F0C7);
        check("t2_upd", 64'(upd_valid), 64'h1);
        check("t2_instr", 64'(upd_instr), 64'h0);
        check("t2_pte", 64'(upd_pte), 64'h2A_F0C7);
        check("t2_vpn", 64'(upd_vpn), 64'h00803);

        // Misaligned 4M superpage
        start32("t3", 1'b0, 32'h00C0_5000, 1'b0);
        rd32("t3_l1", 34'h0_0010_000C, 32'h0000_04CB);
        check("t3_err", 64'(err), 64'h1);
        check("t3_faddr", 64'(fault_addr), 64'h00C0_5000);
        check("t3_noupd", 64'(upd_valid), 64'h0);
        @(negedge clk);
        check("t3_pulse", 64'(err), 64'h0);
        check("t3_busy", 64'(busy), 64'h0);

        // Execute-only leaf on a load: fault without MXR, granted with MXR
        start32("t4a", 1'b1, 32'h0080_3000, 1'b0);
        rd32("t4a_l1", 34'h0_0010_0008, 32'h000C_0001);
        rd32("t4a_l0", 34'h0_0030_000C, 32'h0000_00C9);
        check("t4a_err", 64'(err), 64'h1);
        @(negedge clk);
        mxr = 1'b1;
        start32("t4b", 1'b1, 32'h0080_3000, 1'b0);
        rd32("t4b_l1", 34'h0_0010_0008, 32'h000C_0001);
        rd32("t4b_l0", 34'h0_0030_000C, 32'h0000_00C9);
        check("t4b_err", 64'(err), 64'h0);
        check("t4b_upd", 64'(upd_valid), 64'h1);
        check("t4b_pte", 64'(upd_pte), 64'hC9);
        mxr = 1'b0;
        @(negedge clk);

        // Flush in the grant cycle drains the outstanding read
        start32("t5", 1'b0, 32'h0040_1000, 1'b0);
        wait_req("t5");
        gnt = 1'b1; flush = 1'b1;
        @(negedge clk);
        gnt = 1'b0; flush = 1'b0;
        check("t5_drain_busy", 64'(busy), 64'h1);
        check("t5_drain_req", 64'(mem_req), 64'h0);
        rvalid = 1'b1; rdata = 32'h0008_0021;
        @(negedge clk);
        rvalid = 1'b0;
        check("t5_idle", 64'(busy), 64'h0);
        check("t5_noupd", 64'(upd_valid), 64'h0);
        check("t5_noerr", 64'(err), 64'h0);

        // Simultaneous misses: DTLB first, ITLB taken once the walker is free
        itlb_miss = 1'b1; itlb_va = 32'h0040_1000;
        dtlb_miss = 1'b1; dtlb_va = 32'h0080_3000; is_store = 1'b0;
        #1;
        check("t6_dcnt", 64'(dcnt), 64'h1);
        check("t6_icnt", 64'(icnt), 64'h0);
        @(negedge clk);
        dtlb_miss = 1'b0;
        rd32("t6_l1", 34'h0_0010_0008, 32'h000C_0001);
        rd32("t6_l0", 34'h0_0030_000C, 32'h002A_F0C3);
        check("t6_upd", 64'(upd_valid), 64'h1);
        check("t6_instr", 64'(upd_instr), 64'h0);
        #1;
        check("t6_icnt2", 64'(icnt), 64'h1);
        @(negedge clk);
        itlb_miss = 1'b0;
        check("t6_i_addr", 64'(mem_addr), 64'h10_0004);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("t6_flush_idle", 64'(busy), 64'h0);
        check("t6_flush_req", 64'(mem_req), 64'h0);

        // Reset mid-walk; a late rvalid in IDLE is ignored
        start32("t7", 1'b0, 32'h0040_1000, 1'b0);
        wait_req("t7");
        gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0; rst_n = 1'b0;
        #1;
        check("t7_rst_busy", 64'(busy), 64'h0);
        @(negedge clk);
        rst_n = 1'b1; rvalid = 1'b1; rdata = 32'h0008_0021;
        @(negedge clk);
        rvalid = 1'b0;
        check("t7_busy", 64'(busy), 64'h0);
        check("t7_noupd", 64'(upd_valid), 64'h0);
        check("t7_lvl", 64'(upd_lvl), 64'h1);

        // Sv39: three-level walk to a 4K leaf
        itlb_miss39 = 1'b1; itlb_va39 = 39'h00_4040_3000;
        #1;
        check("t8_icnt", 64'(icnt39), 64'h1);
        @(negedge clk);
        itlb_miss39 = 1'b0;
        rd39("t8_l2", 56'h8000_0008, 64'h2000_0401);
        rd39("t8_l1", 56'h8000_1010, 64'h2000_0801);
        rd39("t8_l0", 56'h8000_2018, 64'h0000_00CB);
        check("t8_upd", 64'(upd_valid39), 64'h1);
        check("t8_lvl", 64'(upd_lvl39), 64'h0);
        check("t8_vpn", 64'(upd_vpn39), 64'h4_0403);
        check("t8_pte", upd_pte39, 64'hCB);
        @(negedge clk);

        // Sv39: 1G leaf at the root level
        itlb_miss39 = 1'b1;
        @(negedge clk);
        itlb_miss39 = 1'b0;
        rd39("t9_l2", 56'h8000_0008, 64'h1000_00CB);
        check("t9_upd", 64'(upd_valid39), 64'h1);
        check("t9_lvl", 64'(upd_lvl39), 64'h2);
        check("t9_pte", upd_pte39, 64'h1000_00CB);
        check("t9_busy", 64'(busy39), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
